dmem_arbiter: RTL and testbench

//  Shares the single data SRAM (write port 0, read port 1, active-low chip selects) between two requesters:

---
 rtl/dmem_arbiter.sv | 160 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port arbiter in front of the 1W/1R data SRAM
// Port A (LSU) has fixed priority; port B gets a starvation guard and a lock mode.
module dmem_arbiter #(
  parameter int DMEM_ADDR_LEN = 8,
  parameter int STARVE_LIM    = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_i,

  input  logic                     a_valid_i,
  output logic                     a_ready_o,
  input  logic                     a_we_i,
  input  logic [DMEM_ADDR_LEN-1:0] a_addr_i,
  input  logic [3:0]               a_wmask_i,
  input  logic [31:0]              a_wdata_i,
  output logic                     a_rsp_valid_o,
  output logic [31:0]              a_rdata_o,

  input  logic                     b_valid_i,
  output logic                     b_ready_o,
  input  logic                     b_we_i,
  input  logic [DMEM_ADDR_LEN-1:0] b_addr_i,
  input  logic [3:0]               b_wmask_i,
  input  logic [31:0]              b_wdata_i,
  output logic                     b_rsp_valid_o,
  output logic [31:0]              b_rdata_o,
  input  logic                     b_lock_i,

  output logic                     mem_csb0_o,
  output logic [3:0]               mem_wmask0_o,
  output logic [DMEM_ADDR_LEN-3:0] mem_addr0_o,
  output logic [31:0]              mem_din0_o,
  output logic                     mem_csb1_o,
  output logic [DMEM_ADDR_LEN-3:0] mem_addr1_o,
  input  logic [31:0]              mem_dout1_i
);

  localparam logic [3:0] STARVE_LIM_W = 4'(STARVE_LIM);

  typedef enum logic [1:0] {
    PRIO_A  = 2'd0,
    FORCE_B = 2'd1,
    LOCK_B  = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] starve_q, starve_d, starve_inc;
  logic       a_gnt, b_gnt, any_gnt;

  // Response tag: port 0 = A, port 1 = B
  logic       rsp_vld_q, rsp_port_q, rsp_we_q;

  logic                     win_we;
  logic [DMEM_ADDR_LEN-1:0] win_addr;
  logic [3:0]               win_wmask;
  logic [31:0]              win_wdata;
  logic                     wr_sel, rd_sel;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{a_addr_i[1:0], b_addr_i[1:0]};

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q  <= PRIO_A;
      starve_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  assign starve_inc = (starve_q == 4'hF) ? starve_q : starve_q + 4'd1;
  assign starve_d   = (b_valid_i && !b_gnt) ? starve_inc : 4'd0;

  always_comb begin
    state_d = state_q;
    case (state_q)
      PRIO_A: begin
        if (b_gnt && b_lock_i) begin
          state_d = LOCK_B;
        end else if (b_valid_i && !b_gnt && (starve_inc >= STARVE_LIM_W)) begin
          state_d = FORCE_B;
        end
      end
      FORCE_B: begin
        if (!b_valid_i) begin
          state_d = PRIO_A;
        end else if (b_lock_i) begin
          state_d = LOCK_B;
        end else begin
          state_d = PRIO_A;
        end
      end
      LOCK_B: begin
        // The request that drops the lock is still served before A regains priority.
        state_d = b_lock_i ? LOCK_B : PRIO_A;
      end
      default: state_d = PRIO_A;
    endcase
  end

  // Grants are qualified by reset so the SRAM stays deselected while reset is held.
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (reset_i) begin
      case (state_q)
        PRIO_A: begin
          a_gnt = a_valid_i;
          b_gnt = !a_valid_i && b_valid_i;
        end
        FORCE_B, LOCK_B: begin
          b_gnt = b_valid_i;
        end
        default: begin
          a_gnt = 1'b0;
          b_gnt = 1'b0;
        end
      endcase
    end
  end

  assign a_ready_o = a_gnt;
  assign b_ready_o = b_gnt;
  assign any_gnt   = a_gnt || b_gnt;

  assign win_we    = b_gnt ? b_we_i    : a_we_i;
  assign win_addr  = b_gnt ? b_addr_i  : a_addr_i;
  assign win_wmask = b_gnt ? b_wmask_i : a_wmask_i;
  assign win_wdata = b_gnt ? b_wdata_i : a_wdata_i;

  assign wr_sel = any_gnt && win_we;
  assign rd_sel = any_gnt && !win_we;

  assign mem_csb0_o   = !wr_sel;
  assign mem_wmask0_o = wr_sel ? win_wmask : 4'd0;
  assign mem_addr0_o  = wr_sel ? win_addr[DMEM_ADDR_LEN-1:2] : '0;
  assign mem_din0_o   = wr_sel ? win_wdata : 32'd0;
  assign mem_csb1_o   = !rd_sel;
  assign mem_addr1_o  = rd_sel ? win_addr[DMEM_ADDR_LEN-1:2] : '0;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      rsp_vld_q  <= 1'b0;
      rsp_port_q <= 1'b0;
      rsp_we_q   <= 1'b0;
    end else begin
      rsp_vld_q  <= any_gnt;
      rsp_port_q <= b_gnt;
      rsp_we_q   <= win_we;
    end
  end

  // SRAM read data arrives the cycle after csb1, i.e. alongside the tag.
  assign a_rsp_valid_o = rsp_vld_q && !rsp_port_q;
  assign b_rsp_valid_o = rsp_vld_q && rsp_port_q;
  assign a_rdata_o     = (a_rsp_valid_o && !rsp_we_q) ? mem_dout1_i : 32'd0;
  assign b_rdata_o     = (b_rsp_valid_o && !rsp_we_q) ? mem_dout1_i : 32'd0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter with a behavioural SRAM
module tb_dmem_arbiter;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        a_valid_i, a_ready_o, a_we_i, a_rsp_valid_o;
  logic [7:0]  a_addr_i;
  logic [3:0]  a_wmask_i;
  logic [31:0] a_wdata_i, a_rdata_o;
  logic        b_valid_i, b_ready_o, b_we_i, b_rsp_valid_o, b_lock_i;
  logic [7:0]  b_addr_i;
  logic [3:0]  b_wmask_i;
  logic [31:0] b_wdata_i, b_rdata_o;
  logic        mem_csb0_o, mem_csb1_o;
  logic [3:0]  mem_wmask0_o;
  logic [5:0]  mem_addr0_o, mem_addr1_o;
  logic [31:0] mem_din0_o, mem_dout1_i;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_a[$];
  logic [31:0] exp_b[$];
  logic [31:0] sram [0:63];

  always #5 clk_i = ~clk_i;

  dmem_arbiter #(.DMEM_ADDR_LEN(8), .STARVE_LIM(4)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .a_valid_i(a_valid_i), .a_ready_o(a_ready_o), .a_we_i(a_we_i), .a_addr_i(a_addr_i),
    .a_wmask_i(a_wmask_i), .a_wdata_i(a_wdata_i), .a_rsp_valid_o(a_rsp_valid_o), .a_rdata_o(a_rdata_o),
    .b_valid_i(b_valid_i), .b_ready_o(b_ready_o), .b_we_i(b_we_i), .b_addr_i(b_addr_i),
    .b_wmask_i(b_wmask_i), .b_wdata_i(b_wdata_i), .b_rsp_valid_o(b_rsp_valid_o), .b_rdata_o(b_rdata_o),
    .b_lock_i(b_lock_i),
    .mem_csb0_o(mem_csb0_o), .mem_wmask0_o(mem_wmask0_o), .mem_addr0_o(mem_addr0_o), .mem_din0_o(mem_din0_o),
    .mem_csb1_o(mem_csb1_o), .mem_addr1_o(mem_addr1_o), .mem_dout1_i(mem_dout1_i)
  );

  // Synchronous 1W/1R SRAM; contents are preloaded whenever reset is held.
  always @(posedge clk_i) begin
    if (!reset_i) begin
      for (int i = 0; i < 64; i++) sram[i] <= 32'h0;
      sram[1]     <= 32'hFFFFFF00;
      sram[4]     <= 32'h11111111;
      sram[8]     <= 32'h22222222;
      mem_dout1_i <= 32'h0;
    end else begin
      if (!mem_csb0_o)
        for (int i = 0; i < 4; i++)
          if (mem_wmask0_o[i]) sram[mem_addr0_o][8*i +: 8] <= mem_din0_o[8*i +: 8];
      if (!mem_csb1_o) mem_dout1_i <= sram[mem_addr1_o];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk_i) begin
    if (a_rsp_valid_o) begin
      if (exp_a.size() == 0) chk("a_rsp_unexpected", 32'd1, 32'd0);
      else chk("a_rdata", a_rdata_o, exp_a.pop_front());
    end
    if (b_rsp_valid_o) begin
      if (exp_b.size() == 0) chk("b_rsp_unexpected", 32'd1, 32'd0);
      else chk("b_rdata", b_rdata_o, exp_b.pop_front());
    end
  end

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic sample();
    @(negedge clk_i);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic we, input logic [7:0] ad,
                         input logic [3:0] m, input logic [31:0] d);
    a_valid_i = v; a_we_i = we; a_addr_i = ad; a_wmask_i = m; a_wdata_i = d;
  endtask

  task automatic drive_b(input logic v, input logic we, input logic [7:0] ad,
                         input logic [3:0] m, input logic [31:0] d, input logic lk);
    b_valid_i = v; b_we_i = we; b_addr_i = ad; b_wmask_i = m; b_wdata_i = d; b_lock_i = lk;
  endtask

  task automatic idle_all();
    drive_a(0, 0, 8'h0, 4'h0, 32'h0);
    drive_b(0, 0, 8'h0, 4'h0, 32'h0, 0);
  endtask

  task automatic chk_ready(input string tag, input logic ea, input logic eb);
    chk({tag, "_a_ready"}, 32'(a_ready_o), 32'(ea));
    chk({tag, "_b_ready"}, 32'(b_ready_o), 32'(eb));
  endtask

  task automatic chk_drained(input string tag);
    chk({tag, "_a_pending"}, 32'(exp_a.size()), 32'd0);
    chk({tag, "_b_pending"}, 32'(exp_b.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    reset_i = 1'b0;
    idle_all();
    cyc(); sample();
    chk_ready("rst", 0, 0);
    chk("rst_csb0", 32'(mem_csb0_o), 32'd1);
    chk("rst_csb1", 32'(mem_csb1_o), 32'd1);
    chk("rst_a_rsp", 32'(a_rsp_valid_o), 32'd0);
    chk("rst_b_rsp", 32'(b_rsp_valid_o), 32'd0);
    chk("rst_a_rdata", a_rdata_o, 32'd0);
    chk("rst_addr1", 32'(mem_addr1_o), 32'd0);
    cyc(); reset_i = 1'b1;

    // Idle bus
    for (int c = 0; c < 3; c++) begin
      cyc(); sample();
      chk_ready("idle", 0, 0);
      chk("idle_csb0", 32'(mem_csb0_o), 32'd1);
      chk("idle_csb1", 32'(mem_csb1_o), 32'd1);
    end

    // Simultaneous loads: A wins, B follows
    cyc();
    drive_a(1, 0, 8'h10, 4'h0, 32'h0);
    drive_b(1, 0, 8'h20, 4'h0, 32'h0, 0);
    sample();
    chk_ready("t1c0", 1, 0);
    chk("t1c0_csb1", 32'(mem_csb1_o), 32'd0);
    chk("t1c0_csb0", 32'(mem_csb0_o), 32'd1);
    chk("t1c0_addr1", 32'(mem_addr1_o), 32'h04);
    exp_a.push_back(32'h11111111);
    cyc(); drive_a(0, 0, 8'h0, 4'h0, 32'h0); sample();
    chk_ready("t1c1", 0, 1);
    chk("t1c1_addr1", 32'(mem_addr1_o), 32'h08);
    exp_b.push_back(32'h22222222);
    cyc(); idle_all(); sample();
    cyc(); sample();
    chk_drained("t1");

    // Starvation guard: B forced through at cycle 4
    for (int c = 0; c < 6; c++) begin
      cyc();
      drive_a(1, 0, 8'h10, 4'h0, 32'h0);
      drive_b(c <= 4, 0, 8'h20, 4'h0, 32'h0, 0);
      sample();
      chk_ready($sformatf("t2c%0d", c), c != 4, c == 4);
      if (c == 4) exp_b.push_back(32'h22222222);
      else exp_a.push_back(32'h11111111);
    end
    cyc(); idle_all(); sample();
    cyc(); sample();
    chk_drained("t2");

    // Lock mode: A stalls while B holds the lock, even when B is idle
    cyc(); drive_b(1, 1, 8'h08, 4'hF, 32'hDEADBEEF, 1); sample();
    chk_ready("t3c0", 0, 1);
    chk("t3c0_csb0", 32'(mem_csb0_o), 32'd0);
    chk("t3c0_csb1", 32'(mem_csb1_o), 32'd1);
    chk("t3c0_addr0", 32'(mem_addr0_o), 32'h02);
    chk("t3c0_din0", mem_din0_o, 32'hDEADBEEF);
    chk("t3c0_wmask0", 32'(mem_wmask0_o), 32'hF);
    exp_b.push_back(32'h0);
    cyc(); drive_a(1, 0, 8'h10, 4'h0, 32'h0); sample();
    chk_ready("t3c1", 0, 1);
    exp_b.push_back(32'h0);
    cyc(); drive_b(0, 0, 8'h0, 4'h0, 32'h0, 1); sample();
    chk_ready("t3c2", 0, 0);
    chk("t3c2_csb0", 32'(mem_csb0_o), 32'd1);
    cyc(); drive_b(1, 1, 8'h08, 4'hF, 32'hDEADBEEF, 0); sample();
    chk_ready("t3c3", 0, 1);
    exp_b.push_back(32'h0);
    cyc(); drive_b(0, 0, 8'h0, 4'h0, 32'h0, 0); sample();
    chk_ready("t3c4", 1, 0);
    exp_a.push_back(32'h11111111);
    cyc(); idle_all(); sample();
    cyc(); sample();
    chk_drained("t3");

    // Store-then-load forwarding through the SRAM, and a zero-mask store
    cyc(); drive_a(1, 1, 8'h04, 4'b0001, 32'h000000AB); sample();
    chk_ready("t4c0", 1, 0);
    chk("t4c0_csb0", 32'(mem_csb0_o), 32'd0);
    chk("t4c0_addr0", 32'(mem_addr0_o), 32'h01);
    chk("t4c0_wmask0", 32'(mem_wmask0_o), 32'h1);
    chk("t4c0_din0", mem_din0_o, 32'h000000AB);
    exp_a.push_back(32'h0);
    cyc(); drive_a(1, 0, 8'h04, 4'h0, 32'h0); sample();
    chk("t4c1_csb1", 32'(mem_csb1_o), 32'd0);
    chk("t4c1_addr1", 32'(mem_addr1_o), 32'h01);
    chk("t4c1_din0", mem_din0_o, 32'h0);
    exp_a.push_back(32'hFFFFFFAB);
    cyc(); drive_a(1, 1, 8'h04, 4'h0, 32'h12345678); sample();
    chk_ready("t4c2", 1, 0);
    chk("t4c2_csb0", 32'(mem_csb0_o), 32'd0);
    chk("t4c2_wmask0", 32'(mem_wmask0_o), 32'h0);
    exp_a.push_back(32'h0);
    cyc(); drive_a(1, 0, 8'h04, 4'h0, 32'h0); sample();
    exp_a.push_back(32'hFFFFFFAB);
    cyc(); drive_a(0, 0, 8'h0, 4'h0, 32'h0); drive_b(1, 0, 8'h08, 4'h0, 32'h0, 0); sample();
    chk_ready("t4c4", 0, 1);
    exp_b.push_back(32'hDEADBEEF);
    cyc(); idle_all(); sample();
    cyc(); sample();
    chk_drained("t4");

    // Reset mid-access drops the in-flight B response
    cyc(); drive_b(1, 0, 8'h20, 4'h0, 32'h0, 0); sample();
    chk_ready("t5c0", 0, 1);
    for (int c = 1; c < 3; c++) begin
      cyc(); reset_i = 1'b0; drive_a(1, 0, 8'h10, 4'h0, 32'h0); sample();
      chk_ready($sformatf("t5c%0d", c), 0, 0);
      chk("t5_b_rsp", 32'(b_rsp_valid_o), 32'd0);
      chk("t5_csb0", 32'(mem_csb0_o), 32'd1);
      chk("t5_csb1", 32'(mem_csb1_o), 32'd1);
    end
    cyc(); reset_i = 1'b1; idle_all(); sample();
    chk("t5_rel_b_rsp", 32'(b_rsp_valid_o), 32'd0);
    cyc(); sample();
    chk("t5_post_b_rsp", 32'(b_rsp_valid_o), 32'd0);
    chk("t5_post_a_rsp", 32'(a_rsp_valid_o), 32'd0);
    chk_drained("end");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
